// File: rtl/dcompressor_stream.sv
// Streaming feed-forward dynamic range compressor: magnitude capture, attack/release
// envelope follower and shift-based gain reduction in a three-stage pipeline.
module dcompressor_stream #(
    parameter int DATA_W          = 16,
    parameter int ENV_FRAC        = 8,
    parameter int ATTACK_SHIFT    = 2,
    parameter int RELEASE_SHIFT   = 6,
    parameter int MAX_RATIO_SHIFT = 3
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    input  logic [DATA_W-2:0] i_threshold,
    input  logic [2:0]        i_ratio_shift,
    input  logic              i_bypass,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [DATA_W-2:0] o_env,
    output logic              o_active
);

    localparam int MAG_W = DATA_W - 1;
    localparam int ENV_W = MAG_W + ENV_FRAC;
    localparam logic [2:0] MAX_RATIO = 3'(MAX_RATIO_SHIFT);

    logic              s1Valid_q, s1Sign_q, s1Bypass_q;
    logic [MAG_W-1:0]  s1Mag_q, s1Thr_q;
    logic [2:0]        s1Ratio_q;
    logic [DATA_W-1:0] absFull;
    logic [MAG_W-1:0]  mag_d;
    logic [2:0]        ratio_d;

    logic              s2Valid_q, s2Sign_q, s2Bypass_q;
    logic [MAG_W-1:0]  s2Mag_q, s2Thr_q;
    logic [2:0]        s2Ratio_q;
    logic [ENV_W-1:0]  env_q, env_d, tgt, diff, step;

    logic [MAG_W-1:0]  envInt, overshoot, red, outMag;
    logic [DATA_W-1:0] outData_d;
    logic              oValid_q, oActive_q;
    logic [DATA_W-1:0] oData_q;
    logic [MAG_W-1:0]  oEnv_q;

    // The most negative sample has no positive counterpart, so its magnitude saturates.
    always_comb begin
        absFull = i_data[DATA_W-1] ? ((~i_data) + DATA_W'(1)) : i_data;
        mag_d   = absFull[DATA_W-1] ? {MAG_W{1'b1}} : absFull[MAG_W-1:0];
        ratio_d = (i_ratio_shift > MAX_RATIO) ? MAX_RATIO : i_ratio_shift;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            s1Valid_q  <= 1'b0;
            s1Sign_q   <= 1'b0;
            s1Bypass_q <= 1'b0;
            s1Mag_q    <= '0;
            s1Thr_q    <= '0;
            s1Ratio_q  <= '0;
        end else begin
            s1Valid_q <= i_valid;
            if (i_valid) begin
                s1Sign_q   <= i_data[DATA_W-1];
                s1Bypass_q <= i_bypass;
                s1Mag_q    <= mag_d;
                s1Thr_q    <= i_threshold;
                s1Ratio_q  <= ratio_d;
            end
        end
    end

    // A minimum step of one keeps the envelope from stalling just short of the target.
    always_comb begin
        tgt   = ENV_W'(s1Mag_q) << ENV_FRAC;
        diff  = '0;
        step  = '0;
        env_d = env_q;
        if (tgt > env_q) begin
            diff  = tgt - env_q;
            step  = diff >> ATTACK_SHIFT;
            if (step == '0) step = ENV_W'(1);
            env_d = env_q + step;
        end else if (tgt < env_q) begin
            diff  = env_q - tgt;
            step  = diff >> RELEASE_SHIFT;
            if (step == '0) step = ENV_W'(1);
            env_d = env_q - step;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            s2Valid_q  <= 1'b0;
            s2Sign_q   <= 1'b0;
            s2Bypass_q <= 1'b0;
            s2Mag_q    <= '0;
            s2Thr_q    <= '0;
            s2Ratio_q  <= '0;
            env_q      <= '0;
        end else begin
            s2Valid_q <= s1Valid_q;
            if (s1Valid_q) begin
                s2Sign_q   <= s1Sign_q;
                s2Bypass_q <= s1Bypass_q;
                s2Mag_q    <= s1Mag_q;
                s2Thr_q    <= s1Thr_q;
                s2Ratio_q  <= s1Ratio_q;
                env_q      <= env_d;
            end
        end
    end

    // Magnitudes never exceed 2^(DATA_W-1)-1, so negation cannot produce the minimum code.
    always_comb begin
        envInt    = env_q[ENV_W-1:ENV_FRAC];
        overshoot = envInt - s2Thr_q;
        red       = '0;
        if (!s2Bypass_q && (envInt > s2Thr_q) && (s2Ratio_q != 3'd0))
            red = overshoot - (overshoot >> s2Ratio_q);
        outMag    = (s2Mag_q > red) ? (s2Mag_q - red) : '0;
        outData_d = s2Sign_q ? (DATA_W'(0) - {1'b0, outMag}) : {1'b0, outMag};
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            oValid_q  <= 1'b0;
            oData_q   <= '0;
            oEnv_q    <= '0;
            oActive_q <= 1'b0;
        end else begin
            oValid_q <= s2Valid_q;
            if (s2Valid_q) begin
                oData_q   <= outData_d;
                oEnv_q    <= envInt;
                oActive_q <= (red != '0);
            end
        end
    end

    assign o_valid  = oValid_q;
    assign o_data   = oData_q;
    assign o_env    = oEnv_q;
    assign o_active = oActive_q;

endmodule
